muldiv_issue: RTL and testbench
===============================

# muldiv_issue

Execute-stage issue and writeback controller for the RV32M multiply/divide unit. It accepts M-extension instructions from the EX stage, drives the `muldiv` start/op/operand handshake, stalls the pipeline while a divide iterates, and registers completed results for the MEM/WB stage. It also drains in-flight divides after a flush, and returns repeated identical divides from a one-entry result cache.

## Interface

Parameters:
- `FUSE_EN`, default 1: enables the one-entry divide result cache. When 0, every divide goes to `muldiv`.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `ex_valid`  in  1  EX holds a valid M-extension instruction
- `ex_op`  in  `md_op_e`  operation
- `ex_rs1`, `ex_rs2`  in  32  operands
- `ex_rd`  in  5  destination register
- `flush`  in  1  kill the instruction in EX (trap/mispredict); overrides `ex_valid`
- `ex_stall`  out  1  hold IF/ID/EX
- `md_start`  out  1  start pulse to `muldiv`
- `md_op`  out  `md_op_e`  op to `muldiv`
- `md_a`, `md_b`  out  32  operands to `muldiv`
- `md_result`  in  32  from `muldiv`
- `md_busy`  in  1  from `muldiv`
- `md_valid`  in  1  from `muldiv`
- `wb_valid`  out  1  registered one-cycle result strobe
- `wb_rd`  out  5  registered destination
- `wb_data`  out  32  registered result

## Operation

- **States:** IDLE, RUN (divide in flight, owned), DRAIN (divide in flight, flushed).
- **Decode.** Define `go = ex_valid & ~flush`, `is_div = ex_op ∈ {DIV, DIVU, REM, REMU}`.
- **IDLE, `go`, MUL-class op:**
  - `md_start=1`; `md_op`/`md_a`/`md_b` are taken combinationally from `ex_*`.
  - `md_valid` arrives the same cycle; `md_result` and `ex_rd` are captured into `wb_*` at the edge.
  - `ex_stall=0`.
- **IDLE, `go`, `is_div`, cache hit** (`FUSE_EN`, cache valid, and op/rs1/rs2 all equal to the cached values):
  - No `md_start`.
  - Cached result goes to `wb_*` at the edge.
  - `ex_stall=0`.
- **IDLE, `go`, `is_div`, miss:**
  - `md_start=1`; latch op/rs1/rs2/rd internally; `ex_stall=1`.
  - Next state is RUN.
- **RUN:**
  - `md_op`/`md_a`/`md_b` come from the latches; `md_start=0`.
  - `ex_stall=1` until `md_valid`.
  - On `md_valid`: `ex_stall=0` that cycle; `wb_*` and the cache (op, a, b, result) are loaded at the edge; next state is IDLE.
  - The controller keys only on `md_valid`, never on a cycle count.
- **RUN with `flush=1` and no `md_valid`:** next state is DRAIN.
  - If `flush` and `md_valid` coincide, the result is discarded, the cache is not updated, and next state is IDLE.
- **DRAIN:**
  - `md_op` stays on the latched divide op; `md_start=0`.
  - `ex_stall = ex_valid` (a new M op waits; non-M instructions are not presented on this interface).
  - On `md_valid`: the result is discarded (no `wb_valid`, no cache update); next state is IDLE.
  - A waiting op issues on the following cycle; there is no same-cycle reissue.
- **IDLE with `flush`:** nothing issues and there is no `wb_valid`.
- **Result values:** division by zero and signed overflow results come from `muldiv` unmodified. MUL results are never cached.
- **Cache:** invalidated only by reset. It holds the last completed, non-flushed divide.

## Timing

- **Reset values:**
  - State: IDLE.
  - `wb_valid=0`, `wb_rd=0`, `wb_data=0`.
  - `ex_stall=0`, `md_start=0`, `md_op=MD_MUL`, `md_a=md_b=0`.
  - Cache invalid.
  - All combinational outputs are forced to these values while `rst_n=0`.
- **MUL and cache hit:** 0 stall cycles; `wb_valid` one cycle after issue.
- **Divide:** `md_start` in cycle 0; with the current 33-step divider, `md_valid` arrives in cycle 34.
  - `ex_stall` is high in cycles 0–33 (34 cycles).
  - `wb_valid` is high in cycle 35.
- **Start pulse:** `md_start` is high for exactly one cycle per issued operation, even when `ex_valid` is held through the stall.
- **Strobe:** `wb_valid` is a single-cycle pulse per retired op. Back-to-back MULs give consecutive pulses.
- **Reset mid-divide:** returns to IDLE immediately. `muldiv` resets on the same `rst_n`.

## Test plan

1. MUL, rs1=7, rs2=0xFFFFFFFD, rd=5 -> `wb_valid` next cycle, `wb_data=0xFFFFFFEB`, `wb_rd=5`, `ex_stall` never high.
2. DIV, rs1=0xFFFFFFEC (−20), rs2=3, `ex_valid` held -> exactly one `md_start`, `ex_stall` high 34 cycles, `wb_data=0xFFFFFFFA`.
3. DIVU, rs1=0x1234, rs2=0 -> `wb_data=0xFFFFFFFF`. An immediate repeat of the same DIVU -> cache hit, no `md_start`, no stall, `wb_data=0xFFFFFFFF`.
4. REM 100/7 (`wb_data=2`), then DIV 100/7 -> cache miss (op differs), full 34-cycle stall, `wb_data=14`.
5. DIV 1000/10, `flush` in cycle 10, then MULHU 0xFFFFFFFF×2 presented -> MULHU stalled until the drained `md_valid`, issues the next cycle, `wb_data=1`; no `wb_valid` for the divide. A later DIV 1000/10 is a cache miss.
6. Assert `rst_n=0` in cycle 20 of a divide -> all outputs at reset values; after release, MUL 3×4 gives `wb_data=12` with no stall.

Source files
------------

// File: rtl/muldiv_issue.sv
// RV32M issue/writeback controller: drives the muldiv handshake, stalls EX during divides,
// drains flushed divides and serves repeated identical divides from a one-entry result cache.
package muldiv_pkg;
    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;
endpackage

module muldiv_issue
    import muldiv_pkg::*;
#(
    parameter bit FUSE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  md_op_e      ex_op,
    input  logic [31:0] ex_rs1,
    input  logic [31:0] ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic        ex_stall,
    output logic        md_start,
    output md_op_e      md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic [31:0] md_result,
    input  logic        md_busy,
    input  logic        md_valid,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

    state_e      state_q;
    logic        wb_valid_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;

    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [4:0]  rd_q;

    logic        c_vld_q;
    md_op_e      c_op_q;
    logic [31:0] c_a_q;
    logic [31:0] c_b_q;
    logic [31:0] c_res_q;

    logic go;
    logic is_div;
    logic hit;
    logic issue_div;
    logic run_done;

    // The controller keys purely on md_valid; busy is kept only for observability.
    logic unused_busy;
    assign unused_busy = md_busy;

    always_comb begin
        go        = ex_valid & ~flush;
        is_div    = ex_op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
        hit       = FUSE_EN && c_vld_q && (ex_op == c_op_q) &&
                    (ex_rs1 == c_a_q) && (ex_rs2 == c_b_q);
        issue_div = (state_q == S_IDLE) && go && is_div && !hit;
        run_done  = (state_q == S_RUN) && md_valid && !flush;

        ex_stall = 1'b0;
        md_start = 1'b0;
        md_op    = MD_MUL;
        md_a     = 32'd0;
        md_b     = 32'd0;
        if (rst_n) begin
            unique case (state_q)
                S_IDLE: begin
                    md_op    = ex_op;
                    md_a     = ex_rs1;
                    md_b     = ex_rs2;
                    md_start = go && !(is_div && hit);
                    ex_stall = issue_div;
                end
                S_RUN: begin
                    md_op    = op_q;
                    md_a     = a_q;
                    md_b     = b_q;
                    ex_stall = !md_valid;
                end
                S_DRAIN: begin
                    // A new M op waits for the orphaned divide and issues the cycle after.
                    md_op    = op_q;
                    md_a     = a_q;
                    md_b     = b_q;
                    ex_stall = ex_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= 32'd0;
            c_vld_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (go) begin
                        if (!is_div) begin
                            if (md_valid) begin
                                wb_valid_q <= 1'b1;
                                wb_rd_q    <= ex_rd;
                                wb_data_q  <= md_result;
                            end
                        end else if (hit) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= ex_rd;
                            wb_data_q  <= c_res_q;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (md_valid) begin
                        state_q <= S_IDLE;
                        if (!flush) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= rd_q;
                            wb_data_q  <= md_result;
                            c_vld_q    <= FUSE_EN;
                        end
                    end else if (flush) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (md_valid) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Operand latches and cache payload carry no reset; c_vld_q qualifies the cache.
    always_ff @(posedge clk) begin
        if (issue_div) begin
            op_q <= ex_op;
            a_q  <= ex_rs1;
            b_q  <= ex_rs2;
            rd_q <= ex_rd;
        end
        if (run_done) begin
            c_op_q  <= op_q;
            c_a_q   <= a_q;
            c_b_q   <= b_q;
            c_res_q <= md_result;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_muldiv_issue.sv
// Bench for muldiv_issue: behavioural 33-step muldiv model plus a queue scoreboard on wb_*.
module tb_muldiv_issue;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    md_op_e      ex_op = MD_MUL;
    logic [31:0] ex_rs1 = '0;
    logic [31:0] ex_rs2 = '0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        ex_stall, md_start, md_busy, md_valid, wb_valid;
    md_op_e      md_op;
    logic [31:0] md_a, md_b, md_result, wb_data;
    logic [4:0]  wb_rd;

    muldiv_issue #(.FUSE_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .flush(flush),
        .ex_stall(ex_stall), .md_start(md_start), .md_op(md_op),
        .md_a(md_a), .md_b(md_b), .md_result(md_result), .md_busy(md_busy),
        .md_valid(md_valid), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    // ---------------- muldiv model ----------------
    function automatic bit is_div_op(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
    endfunction

    function automatic logic [31:0] calc(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0]        ua, ub, p;
        logic [31:0]        r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (op)
            MD_MUL:    r = a * b;
            MD_MULH:   begin p = sa * sb;          r = p[63:32]; end
            MD_MULHSU: begin p = sa * $signed(ub); r = p[63:32]; end
            MD_MULHU:  begin p = ua * ub;          r = p[63:32]; end
            MD_DIV:    if (b == 0) r = 32'hFFFF_FFFF;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                       else r = $signed(a) / $signed(b);
            MD_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    if (b == 0) r = a;
                       else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                       else r = $signed(a) % $signed(b);
            MD_REMU:   r = (b == 0) ? a : a % b;
            default:   r = '0;
        endcase
        return r;
    endfunction

    logic        dv_busy;
    int          dv_cnt;
    logic [31:0] dv_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_busy <= 1'b0;
            dv_cnt  <= 0;
            dv_res  <= '0;
        end else if (md_start && is_div_op(md_op)) begin
            dv_busy <= 1'b1;
            dv_cnt  <= 1;
            dv_res  <= calc(md_op, md_a, md_b);
        end else if (dv_busy) begin
            if (dv_cnt == 34) dv_busy <= 1'b0;
            else dv_cnt <= dv_cnt + 1;
        end
    end

    always_comb begin
        md_busy   = dv_busy;
        md_valid  = (dv_busy && dv_cnt == 34) || (md_start && !is_div_op(md_op));
        md_result = dv_busy ? dv_res : calc(md_op, md_a, md_b);
    end

    // ---------------- checking ----------------
    typedef struct { logic [4:0] rd; logic [31:0] data; } exp_t;
    exp_t exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int stall_cnt = 0;
    int start_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (ex_stall) stall_cnt++;
        if (md_start) start_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_wb_valid", {27'd0, wb_rd}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e.rd = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        ex_valid = 1'b1;
        ex_op    = op;
        ex_rs1   = a;
        ex_rs2   = b;
        ex_rd    = rd;
    endtask

    // Presents an op until accepted; returns stall cycles and start pulses seen meanwhile.
    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int stalls, output int starts);
        int s0, t0;
        bit done;
        s0 = stall_cnt;
        t0 = start_cnt;
        done = 0;
        @(posedge clk); #1;
        drive(op, a, b, rd);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ex_stall) begin done = 1; break; end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        stalls = stall_cnt - s0;
        starts = start_cnt - t0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ex_stall"}, {31'd0, ex_stall}, 32'd0);
        chk({tag, "_md_start"}, {31'd0, md_start}, 32'd0);
        chk({tag, "_md_op"}, {29'd0, md_op}, {29'd0, MD_MUL});
        chk({tag, "_md_a"}, md_a, 32'd0);
        chk({tag, "_md_b"}, md_b, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, sp, s0, t0;
        bit done;

        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: MUL 7 * -3
        push_exp(5'd5, 32'hFFFF_FFEB);
        run_op(MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, st, sp);
        chk("mul_stall", st, 0);
        chk("mul_starts", sp, 1);
        chk("mul_wb_next_cycle", {31'd0, wb_valid}, 32'd1);

        // 2: DIV -20 / 3 with ex_valid held
        push_exp(5'd6, 32'hFFFF_FFFA);
        run_op(MD_DIV, 32'hFFFF_FFEC, 32'd3, 5'd6, st, sp);
        chk("div_stall", st, 34);
        chk("div_starts", sp, 1);
        chk("div_wb_cycle35", {31'd0, wb_valid}, 32'd1);

        // 3: DIVU by zero, then an identical repeat served from the cache
        push_exp(5'd7, 32'hFFFF_FFFF);
        run_op(MD_DIVU, 32'h1234, 32'd0, 5'd7, st, sp);
        chk("divu0_stall", st, 34);
        push_exp(5'd8, 32'hFFFF_FFFF);
        run_op(MD_DIVU, 32'h1234, 32'd0, 5'd8, st, sp);
        chk("hit_stall", st, 0);
        chk("hit_starts", sp, 0);
        chk("hit_wb_next_cycle", {31'd0, wb_valid}, 32'd1);

        // 4: REM then DIV on the same operands must miss
        push_exp(5'd9, 32'd2);
        run_op(MD_REM, 32'd100, 32'd7, 5'd9, st, sp);
        chk("rem_stall", st, 34);
        push_exp(5'd10, 32'd14);
        run_op(MD_DIV, 32'd100, 32'd7, 5'd10, st, sp);
        chk("div_after_rem_stall", st, 34);
        chk("div_after_rem_starts", sp, 1);

        // 5: flush in cycle 10 of a divide, MULHU waits for the drain
        t0 = start_cnt;
        @(posedge clk); #1;
        drive(MD_DIV, 32'd1000, 32'd10, 5'd3);
        repeat (10) @(posedge clk);
        #1;
        ex_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        s0 = stall_cnt;
        push_exp(5'd11, 32'd1);
        drive(MD_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd11);
        done = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ex_stall) begin done = 1; break; end
        end
        if (!done) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        chk("drain_stall", stall_cnt - s0, 24);
        chk("flush_starts", start_cnt - t0, 2);
        push_exp(5'd12, 32'd100);
        run_op(MD_DIV, 32'd1000, 32'd10, 5'd12, st, sp);
        chk("post_flush_div_miss_stall", st, 34);
        chk("post_flush_div_starts", sp, 1);

        // 6: asynchronous reset in cycle 20 of a divide
        @(posedge clk); #1;
        drive(MD_DIV, 32'd50, 32'd5, 5'd13);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        ex_valid = 1'b0;
        rst_n = 1'b1;
        push_exp(5'd14, 32'd12);
        run_op(MD_MUL, 32'd3, 32'd4, 5'd14, st, sp);
        chk("post_reset_mul_stall", st, 0);

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
